// File: rtl/secuenciador_melodia_if.sv
// -----------------------------------------------------------------------------
// secuenciador_melodia_if
// Bundle between the melody sequencer, its control logic, the song ROM and
// the speaker pin.
//
//   start, stop, loop_en : playback control into the sequencer
//   indice_nota          : ROM address, driven by the sequencer
//   semi_periodo         : half-period in clocks read from the ROM (0 = rest)
//   duracion             : note length in ticks read from the ROM (0 = end mark)
//   parlante             : square-wave speaker output
//   ocupado              : sequencer is not idle
//   fin                  : one-cycle end-of-song pulse
//
// Modports: master = environment (control + ROM), slave = sequencer.
// -----------------------------------------------------------------------------
interface secuenciador_melodia_if #(
   parameter int unsigned IDX_W = 5,
   parameter int unsigned PER_W = 16,
   parameter int unsigned DUR_W = 8
);

   logic             start;
   logic             stop;
   logic             loop_en;
   logic [IDX_W-1:0] indice_nota;
   logic [PER_W-1:0] semi_periodo;
   logic [DUR_W-1:0] duracion;
   logic             parlante;
   logic             ocupado;
   logic             fin;

   modport master (
      output start,
      output stop,
      output loop_en,
      output semi_periodo,
      output duracion,
      input  indice_nota,
      input  parlante,
      input  ocupado,
      input  fin
   );

   modport slave (
      input  start,
      input  stop,
      input  loop_en,
      input  semi_periodo,
      input  duracion,
      output indice_nota,
      output parlante,
      output ocupado,
      output fin
   );

endinterface

// File: rtl/secuenciador_melodia.sv
// -----------------------------------------------------------------------------
// secuenciador_melodia
// Melody sequencer and square-wave tone generator. Walks a combinational song
// ROM (half-period + duration per entry), plays each entry on the speaker pin,
// inserts an optional silent gap after every note and supports rests, an
// end-of-song marker, looping, start and stop.
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : secuenciador_melodia_if.slave (control in, ROM fields in,
//           ROM address / speaker / busy / end pulse out)
//
// Parameters:
//   N_NOTAS   : maximum entries per song
//   TICK_CLKS : clocks per duration tick
//   DUR_W     : duration field width (ticks)
//   PER_W     : half-period field width (clocks)
//   GAP_TICKS : silent ticks after every note, 0 disables the gap
// -----------------------------------------------------------------------------
module secuenciador_melodia #(
   parameter int unsigned N_NOTAS   = 25,
   parameter int unsigned TICK_CLKS = 120000,
   parameter int unsigned DUR_W     = 8,
   parameter int unsigned PER_W     = 16,
   parameter int unsigned GAP_TICKS = 1
) (
   input logic                   clk,
   input logic                   rst_n,
   secuenciador_melodia_if.slave bus
);

   localparam int unsigned IDX_W  = (N_NOTAS > 1) ? $clog2(N_NOTAS) : 1;
   localparam int unsigned TICK_W = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;

   localparam logic [IDX_W-1:0]  ULT_IDX  = IDX_W'(N_NOTAS - 1);
   localparam logic [TICK_W-1:0] ULT_TICK = TICK_W'(TICK_CLKS - 1);
   // Last gap tick index; unused when the gap is disabled.
   localparam logic [DUR_W-1:0]  ULT_GAP  = (GAP_TICKS > 0) ? DUR_W'(GAP_TICKS - 1) : '0;
   localparam bit                HAY_GAP  = (GAP_TICKS > 0);

   typedef enum logic [1:0] {
      StIdle,
      StCarga,
      StNota,
      StPausa
   } estado_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   estado_e            r_estado;
   logic [IDX_W-1:0]   r_indice;
   logic [PER_W-1:0]   r_per;
   logic [DUR_W-1:0]   r_dur;
   logic [TICK_W-1:0]  r_tick;
   logic [DUR_W-1:0]   r_cnt_dur;
   logic [PER_W-1:0]   r_onda;
   logic               r_parlante;
   logic               r_fin;

   // Next-state
   estado_e            w_estado_d;
   logic [IDX_W-1:0]   w_indice_d;
   logic [PER_W-1:0]   w_per_d;
   logic [DUR_W-1:0]   w_dur_d;
   logic [TICK_W-1:0]  w_tick_d;
   logic [DUR_W-1:0]   w_cnt_dur_d;
   logic [PER_W-1:0]   w_onda_d;
   logic               w_parlante_d;
   logic               w_fin_d;

   // Helpers
   logic               w_ult_tick;
   logic               w_fin_nota;
   logic               w_fin_pausa;
   logic               w_avanzar;

   assign w_ult_tick  = (r_tick == ULT_TICK);
   assign w_fin_nota  = w_ult_tick && (r_cnt_dur == (r_dur - DUR_W'(1)));
   assign w_fin_pausa = w_ult_tick && (r_cnt_dur == ULT_GAP);

   // ---------------------------------------------------------------------------
   // Next-state / outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      w_estado_d   = r_estado;
      w_indice_d   = r_indice;
      w_per_d      = r_per;
      w_dur_d      = r_dur;
      // Counters and speaker fall back to 0 unless a state keeps them running,
      // which also clears them on entry to NOTA/PAUSA.
      w_tick_d     = '0;
      w_cnt_dur_d  = '0;
      w_onda_d     = '0;
      w_parlante_d = 1'b0;
      w_fin_d      = 1'b0;
      w_avanzar    = 1'b0;

      unique case (r_estado)
         StIdle: begin
            if (bus.start) begin
               w_estado_d = StCarga;
               w_indice_d = '0;
            end
         end

         StCarga: begin
            if (bus.duracion == '0) begin
               w_fin_d    = 1'b1;
               w_indice_d = '0;
               // An end marker at index 0 is an empty song: never loop on it.
               w_estado_d = (bus.loop_en && (r_indice != '0)) ? StCarga : StIdle;
            end else begin
               w_per_d    = bus.semi_periodo;
               w_dur_d    = bus.duracion;
               w_estado_d = StNota;
            end
         end

         StNota: begin
            if (w_fin_nota) begin
               if (HAY_GAP) begin
                  w_estado_d = StPausa;
               end else begin
                  w_avanzar = 1'b1;
               end
            end else begin
               w_tick_d    = w_ult_tick ? '0 : r_tick + TICK_W'(1);
               w_cnt_dur_d = w_ult_tick ? r_cnt_dur + DUR_W'(1) : r_cnt_dur;
               // Rest notes keep the wave counter and speaker at 0.
               if (r_per != '0) begin
                  if (r_onda == (r_per - PER_W'(1))) begin
                     w_onda_d     = '0;
                     w_parlante_d = ~r_parlante;
                  end else begin
                     w_onda_d     = r_onda + PER_W'(1);
                     w_parlante_d = r_parlante;
                  end
               end
            end
         end

         StPausa: begin
            if (w_fin_pausa) begin
               w_avanzar = 1'b1;
            end else begin
               w_tick_d    = w_ult_tick ? '0 : r_tick + TICK_W'(1);
               w_cnt_dur_d = w_ult_tick ? r_cnt_dur + DUR_W'(1) : r_cnt_dur;
            end
         end

         default: begin
            w_estado_d = StIdle;
         end
      endcase

      // Advance to the next entry, or wrap/finish after the last one.
      if (w_avanzar) begin
         if (r_indice == ULT_IDX) begin
            w_fin_d    = 1'b1;
            w_indice_d = '0;
            w_estado_d = bus.loop_en ? StCarga : StIdle;
         end else begin
            w_indice_d = r_indice + IDX_W'(1);
            w_estado_d = StCarga;
         end
      end

      // Stop overrides everything, including a start in IDLE.
      if (bus.stop) begin
         w_estado_d   = StIdle;
         w_indice_d   = '0;
         w_tick_d     = '0;
         w_cnt_dur_d  = '0;
         w_onda_d     = '0;
         w_parlante_d = 1'b0;
         w_fin_d      = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado   <= StIdle;
         r_indice   <= '0;
         r_per      <= '0;
         r_dur      <= '0;
         r_tick     <= '0;
         r_cnt_dur  <= '0;
         r_onda     <= '0;
         r_parlante <= 1'b0;
         r_fin      <= 1'b0;
      end else begin
         r_estado   <= w_estado_d;
         r_indice   <= w_indice_d;
         r_per      <= w_per_d;
         r_dur      <= w_dur_d;
         r_tick     <= w_tick_d;
         r_cnt_dur  <= w_cnt_dur_d;
         r_onda     <= w_onda_d;
         r_parlante <= w_parlante_d;
         r_fin      <= w_fin_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.indice_nota = r_indice;
   assign bus.parlante    = r_parlante;
   assign bus.ocupado     = (r_estado != StIdle);
   assign bus.fin         = r_fin;

endmodule
